// File: rtl/lsu_mem_port.sv
// Load/store unit on the initiator side of a word-addressed data RAM.
// Converts byte/half/word requests to word accesses, with read-modify-write for sub-word stores.
module lsu_mem_port #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    localparam logic [29:0] WORD_LIMIT = 30'(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        signed_q, signed_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr);
        logic e;
        e = 1'b0;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = addr[0];
            2'b10:   e = (addr[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e | (addr[31:2] >= WORD_LIMIT);
    endfunction

    // Little-endian lane extraction followed by sign or zero extension.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Next-state and datapath register updates.
    always_comb begin
        state_d          = state_q;
        size_d           = size_q;
        lane_d           = lane_q;
        signed_d         = signed_q;
        wdata_d          = wdata_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        resp_rdata_d     = resp_rdata_q;
        resp_err_d       = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d       = req_size;
                    lane_d       = req_addr[1:0];
                    signed_d     = req_signed;
                    wdata_d      = req_wdata;
                    resp_rdata_d = 32'h0000_0000;
                    if (req_error(req_size, req_addr)) begin
                        // Errors leave the RAM-facing address untouched.
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        resp_err_d    = 1'b0;
                        mem_address_d = 32'(req_addr[IDX_W+1:2]);
                        if (!req_write) begin
                            state_d = S_RD;
                        end else if (req_size == 2'b10) begin
                            mem_write_data_d = req_wdata;
                            state_d          = S_WR;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                resp_rdata_d = load_extend(mem_read_data, size_q, lane_q, signed_q);
                state_d      = S_RESP;
            end
            S_RMW_RD: begin
                // The write-data register doubles as the merge register.
                mem_write_data_d = store_merge(mem_read_data, wdata_q, size_q, lane_q);
                state_d          = S_WR;
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            size_q           <= 2'b00;
            lane_q           <= 2'b00;
            signed_q         <= 1'b0;
            wdata_q          <= 32'h0000_0000;
            mem_address_q    <= 32'h0000_0000;
            mem_write_data_q <= 32'h0000_0000;
            resp_rdata_q     <= 32'h0000_0000;
            resp_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            size_q           <= size_d;
            lane_q           <= lane_d;
            signed_q         <= signed_d;
            wdata_q          <= wdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE) && !reset;
    assign mem_MemRead    = ((state_q == S_RD) || (state_q == S_RMW_RD)) && !reset;
    assign mem_MemWrite   = (state_q == S_WR) && !reset;
    assign resp_valid     = (state_q == S_RESP) && !reset;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port with a behavioural 64-word RAM.
module tb_lsu_mem_port;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_read_data;

    logic [31:0] ram [0:63];
    int checks;
    int errors;

    lsu_mem_port #(.DEPTH_WORDS(64), .IDX_W(6)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = ram[mem_address[5:0]];

    always @(posedge clk) begin
        if (mem_MemWrite) ram[mem_address[5:0]] <= mem_write_data;
    end

    // Issue one request from a negedge; reports latency (cycles after accept), pulse counts and response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output int nrd, output int nwr,
                         output logic [31:0] rdata, output logic err, output logic [31:0] wr_word);
        int guard;
        logic got;
        guard = 0; got = 1'b0;
        lat = -1; nrd = 0; nwr = 0; rdata = 32'hxxxx_xxxx; err = 1'bx; wr_word = 32'h0000_0000;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (mem_MemRead) nrd++;
            if (mem_MemWrite) begin
                nwr++;
                wr_word = mem_write_data;
            end
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err; got = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", req_ready); end
        checks++;
        if ({resp_valid, mem_MemRead, mem_MemWrite} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000", {resp_valid, mem_MemRead, mem_MemWrite});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", req_ready); end
        checks++;
        if ({mem_address, mem_write_data, resp_rdata} !== 96'h0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_regs: got addr %h wdata %h rdata %h err %b expected zeros",
                               mem_address, mem_write_data, resp_rdata, resp_err);
        end
    endtask

    task automatic test_word_load();
        int lat, nrd, nwr;
        logic [31:0] rd, ww;
        logic er;
        ram[5] <= 32'h0000_006D;
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, nrd, nwr, rd, er, ww);
        checks++;
        if (lat !== 2 || nrd !== 1 || nwr !== 0) begin
            errors++; $display("FAIL word_load_timing: got lat %0d rd %0d wr %0d expected 2 1 0", lat, nrd, nwr);
        end
        checks++;
        if (rd !== 32'h0000_006D || er !== 1'b0) begin
            errors++; $display("FAIL word_load_data: got %h err %b expected 0000006d err 0", rd, er);
        end
    endtask

    task automatic test_sub_load();
        logic [31:0] addr_t [5] = '{32'h1E, 32'h1E, 32'h1E, 32'h1E, 32'h1C};
        logic [1:0]  size_t [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        sgn_t  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_t  [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_0005};
        int lat, nrd, nwr;
        logic [31:0] rd, ww;
        logic er;
        ram[7] <= 32'h80FF_0005;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, size_t[i], sgn_t[i], addr_t[i], 32'h0, lat, nrd, nwr, rd, er, ww);
            checks++;
            if (rd !== exp_t[i] || er !== 1'b0 || lat !== 2) begin
                errors++; $display("FAIL sub_load_%0d: got %h err %b lat %0d expected %h err 0 lat 2",
                                   i, rd, er, lat, exp_t[i]);
            end
        end
    endtask

    task automatic test_stores();
        int lat, nrd, nwr;
        logic [31:0] rd, ww;
        logic er;
        ram[62] <= 32'h0000_0009;
        ram[10] <= 32'h1122_3344;
        ram[11] <= 32'h0000_0000;
        @(negedge clk);
        issue(1'b1, 2'b00, 1'b0, 32'hF9, 32'h0000_00AB, lat, nrd, nwr, rd, er, ww);
        checks++;
        if (lat !== 3 || nrd !== 1 || nwr !== 1 || ww !== 32'h0000_AB09) begin
            errors++; $display("FAIL byte_store: got lat %0d rd %0d wr %0d data %h expected 3 1 1 0000ab09",
                               lat, nrd, nwr, ww);
        end
        checks++;
        if (ram[62] !== 32'h0000_AB09 || rd !== 32'h0 || er !== 1'b0) begin
            errors++; $display("FAIL byte_store_ram: got %h rdata %h err %b expected 0000ab09 0 0", ram[62], rd, er);
        end
        issue(1'b0, 2'b10, 1'b0, 32'hF8, 32'h0, lat, nrd, nwr, rd, er, ww);
        checks++;
        if (rd !== 32'h0000_AB09) begin errors++; $display("FAIL byte_store_readback: got %h expected 0000ab09", rd); end
        issue(1'b1, 2'b01, 1'b0, 32'h2A, 32'hFFFF_BEEF, lat, nrd, nwr, rd, er, ww);
        checks++;
        if (lat !== 3 || ram[10] !== 32'hBEEF_3344) begin
            errors++; $display("FAIL half_store: got lat %0d ram %h expected 3 beef3344", lat, ram[10]);
        end
        issue(1'b1, 2'b10, 1'b0, 32'h2C, 32'hDEAD_BEEF, lat, nrd, nwr, rd, er, ww);
        checks++;
        if (lat !== 2 || nrd !== 0 || nwr !== 1 || ram[11] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL word_store: got lat %0d rd %0d wr %0d ram %h expected 2 0 1 deadbeef",
                               lat, nrd, nwr, ram[11]);
        end
    endtask

    task automatic test_errors();
        logic        w_t    [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  size_t [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
        logic [31:0] addr_t [5] = '{32'h03, 32'h102, 32'h00, 32'h100, 32'h8000_0000};
        int lat, nrd, nwr;
        logic [31:0] rd, ww;
        logic er;
        for (int i = 0; i < 5; i++) begin
            issue(w_t[i], size_t[i], 1'b0, addr_t[i], 32'h1234_5678, lat, nrd, nwr, rd, er, ww);
            checks++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0) begin
                errors++; $display("FAIL error_%0d: got lat %0d err %b rdata %h rd %0d wr %0d expected 1 1 0 0 0",
                                   i, lat, er, rd, nrd, nwr);
            end
        end
        ram[63] <= 32'hCAFE_F00D;
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, lat, nrd, nwr, rd, er, ww);
        checks++;
        if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL last_word_load: got %h err %b expected cafef00d err 0", rd, er);
        end
    endtask

    task automatic test_reset_mid_op();
        int nresp, nwr;
        ram[3] <= 32'h1234_5678;
        @(negedge clk);
        nresp = 0; nwr = 0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_addr = 32'h0C; req_wdata = 32'h0000_AAAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        if (mem_MemWrite) nwr++;
        if (resp_valid) nresp++;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_MemWrite) nwr++;
            if (resp_valid) nresp++;
            if (c == 0) begin
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("FAIL midop_ready: got %b expected 1", req_ready); end
            end
        end
        checks++;
        if (nwr !== 0 || nresp !== 0) begin
            errors++; $display("FAIL midop_pulses: got wr %0d resp %0d expected 0 0", nwr, nresp);
        end
        checks++;
        if (ram[3] !== 32'h1234_5678) begin errors++; $display("FAIL midop_ram: got %h expected 12345678", ram[3]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_t [3] = '{32'hA000_0014, 32'hB000_0015, 32'hC000_0016};
        int resp_cyc [3];
        int idx, nresp, ready_bad;
        logic accepting;
        ram[20] <= exp_t[0];
        ram[21] <= exp_t[1];
        ram[22] <= exp_t[2];
        @(negedge clk);
        idx = 0; nresp = 0; ready_bad = 0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h50;
        for (int c = 0; c < 20; c++) begin
            accepting = req_ready && (idx < 3);
            @(posedge clk);
            #1;
            if (accepting) begin
                idx++;
                if (idx == 3) req_valid = 1'b0;
                else req_addr = 32'h50 + 32'(4 * idx);
            end
            @(negedge clk);
            if ((mem_MemRead || resp_valid) && req_ready) ready_bad++;
            if (resp_valid) begin
                if (nresp < 3) begin
                    resp_cyc[nresp] = c;
                    checks++;
                    if (resp_rdata !== exp_t[nresp]) begin
                        errors++; $display("FAIL b2b_data_%0d: got %h expected %h", nresp, resp_rdata, exp_t[nresp]);
                    end
                end
                nresp++;
            end
        end
        checks++;
        if (nresp !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", nresp); end
        else begin
            checks++;
            if (resp_cyc[1] - resp_cyc[0] !== 3 || resp_cyc[2] - resp_cyc[1] !== 3) begin
                errors++; $display("FAIL b2b_spacing: got %0d %0d expected 3 3",
                                   resp_cyc[1] - resp_cyc[0], resp_cyc[2] - resp_cyc[1]);
            end
        end
        checks++;
        if (ready_bad !== 0) begin errors++; $display("FAIL b2b_ready: got %0d busy-ready cycles expected 0", ready_bad); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word_load();
        test_sub_load();
        test_stores();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
